// File: rtl/random_pkg.sv
`default_nettype none
// ============================================================================
// Module      : random_pkg
// Description : Shared types and helpers for the LFSR random code generator.
//               - fsm_t       : sampler states (SEARCH, VALID)
//               - c_taps_w*   : maximal-length feedback masks for common widths
//               - lfsr_next() : one Fibonacci shift step on a 32-bit container
// Revision    : 1.0 - initial release
// ============================================================================
package random_pkg;

  // Sampler state: SEARCH hunts for an acceptable candidate, VALID holds it.
  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    VALID  = 1'b1
  } fsm_t;

  // Maximal-length feedback masks (bit i set = state[i] feeds the XOR).
  localparam logic [3:0]  c_taps_w4  = 4'h9;
  localparam logic [7:0]  c_taps_w8  = 8'hB8;
  localparam logic [15:0] c_taps_w16 = 16'hB400;
  localparam logic [31:0] c_taps_w32 = 32'h80200003;

  // One Fibonacci step: shift left, feedback bit enters at bit 0.
  // Callers zero-extend a narrower state and mask into 32 bits, then keep
  // only their low WIDTH bits; unused upper tap bits must be zero.
  function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                            input logic [31:0] taps);
    return {state[30:0], ^(state & taps)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_core.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_core
// Description : WIDTH-bit Fibonacci LFSR with seed load and lock-up guard.
//   clk      in  : rising-edge clock
//   preset_n in  : asynchronous active-low reset (state <= SEED)
//   en       in  : advance one step this cycle
//   load     in  : load seed this cycle (wins over en)
//   seed     in  : seed value; zero is replaced by SEED
//   state    out : current LFSR state
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_core
  import random_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = c_taps_w8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
  input  logic             clk,
  input  logic             preset_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_next;

  always_comb begin
    w_step = WIDTH'(lfsr_next(32'(r_state), 32'(TAPS)));
    w_next = r_state;
    if (load) begin
      // An all-zero seed would lock the register; substitute SEED.
      w_next = (seed == '0) ? SEED : seed;
    end else if (en) begin
      // With a non-maximal tap mask a step can still reach zero.
      w_next = (w_step == '0) ? SEED : w_step;
    end
  end

  always_ff @(posedge clk or negedge preset_n) begin
    if (!preset_n) begin
      r_state <= SEED;
    end else begin
      r_state <= w_next;
    end
  end

  assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/lfsr_random_gen.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_random_gen
// Description : Bounded pseudo-random code source. An LFSR supplies one
//               OUT_W-bit candidate per enabled cycle; candidates at or above
//               a runtime limit are rejected, and after MAX_TRIES consecutive
//               rejections a fallback 0 is delivered instead. Samples leave
//               over a valid/ready handshake and are held until taken.
//   clk         in  : rising-edge clock
//   preset_n    in  : asynchronous active-low reset
//   en_i        in  : advance LFSR and sampler this cycle
//   seed_we_i   in  : load seed_i (restarts sampling)
//   seed_i      in  : seed value, zero maps to SEED
//   limit_i     in  : accept candidate only if below this; 0 = no limit
//   rnd_valid_o out : sample available
//   rnd_ready_i in  : consumer accepts sample
//   rnd_o       out : held sample
//   fallback_o  out : held sample is the fallback 0
//   state_o     out : raw LFSR state (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_random_gen
  import random_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               OUT_W     = 4,
  parameter logic [WIDTH-1:0] TAPS      = c_taps_w8,
  parameter logic [WIDTH-1:0] SEED      = 8'h01,
  parameter int               MAX_TRIES = 4
) (
  input  logic             clk,
  input  logic             preset_n,
  input  logic             en_i,
  input  logic             seed_we_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic [OUT_W-1:0] limit_i,
  output logic             rnd_valid_o,
  input  logic             rnd_ready_i,
  output logic [OUT_W-1:0] rnd_o,
  output logic             fallback_o,
  output logic [WIDTH-1:0] state_o
);

  localparam logic [7:0] c_last_try = 8'(MAX_TRIES - 1);

  fsm_t             r_fsm;
  fsm_t             w_fsm_next;
  logic [7:0]       r_tries;
  logic [7:0]       w_tries_next;
  logic [OUT_W-1:0] r_rnd;
  logic [OUT_W-1:0] w_rnd_next;
  logic             r_fallback;
  logic             w_fallback_next;

  logic [WIDTH-1:0] w_state;
  logic [OUT_W-1:0] w_cand;
  logic             w_accept;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_lfsr (
    .clk      (clk),
    .preset_n (preset_n),
    .en       (en_i),
    .load     (seed_we_i),
    .seed     (seed_i),
    .state    (w_state)
  );

  // Candidate is taken from the state before this cycle's step.
  assign w_cand   = w_state[OUT_W-1:0];
  assign w_accept = (limit_i == '0) || (w_cand < limit_i);

  always_comb begin
    w_fsm_next      = r_fsm;
    w_tries_next    = r_tries;
    w_rnd_next      = r_rnd;
    w_fallback_next = r_fallback;

    if (seed_we_i) begin
      // A new seed discards any held sample; a transfer coinciding with the
      // load has already been seen by the consumer, so nothing is lost.
      w_fsm_next      = SEARCH;
      w_tries_next    = '0;
      w_fallback_next = 1'b0;
    end else begin
      case (r_fsm)
        SEARCH: begin
          if (en_i) begin
            if (w_accept) begin
              w_rnd_next      = w_cand;
              w_fallback_next = 1'b0;
              w_tries_next    = '0;
              w_fsm_next      = VALID;
            end else if (r_tries == c_last_try) begin
              w_rnd_next      = '0;
              w_fallback_next = 1'b1;
              w_tries_next    = '0;
              w_fsm_next      = VALID;
            end else begin
              w_tries_next = r_tries + 8'd1;
            end
          end
        end
        VALID: begin
          // The handshake completes regardless of en_i.
          if (rnd_ready_i) begin
            w_fsm_next = SEARCH;
          end
        end
        default: begin
          w_fsm_next = SEARCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge preset_n) begin
    if (!preset_n) begin
      r_fsm      <= SEARCH;
      r_tries    <= '0;
      r_rnd      <= '0;
      r_fallback <= 1'b0;
    end else begin
      r_fsm      <= w_fsm_next;
      r_tries    <= w_tries_next;
      r_rnd      <= w_rnd_next;
      r_fallback <= w_fallback_next;
    end
  end

  assign rnd_valid_o = (r_fsm == VALID);
  assign rnd_o       = r_rnd;
  assign fallback_o  = r_fallback;
  assign state_o     = w_state;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_random_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_random_gen
// Description : Self-checking bench for lfsr_random_gen (default parameters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_random_gen;

  localparam int         W    = 8;
  localparam int         OW   = 4;
  localparam int         MT   = 4;
  localparam logic [7:0] TAPS = 8'hB8;
  localparam logic [7:0] SEED = 8'h01;

  logic          clk = 1'b0;
  logic          preset_n = 1'b0;
  logic          en_i = 1'b0;
  logic          seed_we_i = 1'b0;
  logic [W-1:0]  seed_i = '0;
  logic [OW-1:0] limit_i = '0;
  logic          rnd_ready_i = 1'b0;
  logic          rnd_valid_o;
  logic [OW-1:0] rnd_o;
  logic          fallback_o;
  logic [W-1:0]  state_o;

  always #5 clk = ~clk;

  lfsr_random_gen #(
    .WIDTH     (W),
    .OUT_W     (OW),
    .TAPS      (TAPS),
    .SEED      (SEED),
    .MAX_TRIES (MT)
  ) dut (
    .clk         (clk),
    .preset_n    (preset_n),
    .en_i        (en_i),
    .seed_we_i   (seed_we_i),
    .seed_i      (seed_i),
    .limit_i     (limit_i),
    .rnd_valid_o (rnd_valid_o),
    .rnd_ready_i (rnd_ready_i),
    .rnd_o       (rnd_o),
    .fallback_o  (fallback_o),
    .state_o     (state_o)
  );

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference LFSR step written bit by bit from the tap mask.
  function automatic logic [7:0] model_step(input logic [7:0] s);
    logic       fb;
    logic [7:0] n;
    fb = 1'b0;
    for (int i = 0; i < W; i++) if (TAPS[i]) fb ^= s[i];
    n = {s[6:0], fb};
    return (n == 8'h00) ? SEED : n;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench at a falling edge, reset released: "cycle 0".
  task automatic do_reset();
    @(negedge clk);
    preset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    preset_n = 1'b1;
  endtask

  typedef struct {
    bit         rst;
    bit         en;
    bit         rdy;
    logic [3:0] lim;
    logic [7:0] st;
    bit         v;
    logic [3:0] r;
    bit         f;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  // Scoreboard entries: {fallback, rnd}
  logic [4:0] sb_q [$];

  initial begin
    logic [7:0] s;
    logic [4:0] got;
    logic [4:0] exp_e;
    bit         zero_seen;
    int         first_ret;
    int         mism;
    logic [7:0] m_state;
    bit         m_valid;
    logic [7:0] m_tries;
    bit         r_en, r_rdy, r_we;
    logic [3:0] r_lim;
    logic [7:0] r_seed;
    logic [3:0] cand;

    // Rejection: limit 3, ready high
    tbl[0]  = '{1, 1, 1, 4'd3, 8'h01, 0, 4'd0, 0};
    tbl[1]  = '{0, 1, 1, 4'd3, 8'h02, 1, 4'd1, 0};
    tbl[2]  = '{0, 1, 1, 4'd3, 8'h04, 0, 4'd0, 0};
    tbl[3]  = '{0, 1, 1, 4'd3, 8'h08, 0, 4'd0, 0};
    tbl[4]  = '{0, 1, 1, 4'd3, 8'h11, 0, 4'd0, 0};
    tbl[5]  = '{0, 1, 1, 4'd3, 8'h23, 1, 4'd1, 0};
    tbl[6]  = '{0, 1, 1, 4'd3, 8'h47, 0, 4'd0, 0};
    // Fallback: limit 1, four rejections
    tbl[7]  = '{1, 1, 1, 4'd1, 8'h01, 0, 4'd0, 0};
    tbl[8]  = '{0, 1, 1, 4'd1, 8'h02, 0, 4'd0, 0};
    tbl[9]  = '{0, 1, 1, 4'd1, 8'h04, 0, 4'd0, 0};
    tbl[10] = '{0, 1, 1, 4'd1, 8'h08, 0, 4'd0, 0};
    tbl[11] = '{0, 1, 1, 4'd1, 8'h11, 1, 4'd0, 1};
    // en=0 freezes LFSR and FSM but the handshake still completes
    tbl[12] = '{1, 0, 1, 4'd0, 8'h01, 0, 4'd0, 0};
    tbl[13] = '{0, 0, 1, 4'd0, 8'h01, 0, 4'd0, 0};
    tbl[14] = '{0, 1, 1, 4'd0, 8'h01, 0, 4'd0, 0};
    tbl[15] = '{0, 0, 1, 4'd0, 8'h02, 1, 4'd1, 0};
    tbl[16] = '{0, 1, 1, 4'd0, 8'h02, 0, 4'd0, 0};
    tbl[17] = '{0, 1, 1, 4'd0, 8'h04, 1, 4'd2, 0};

    // ---- reset state ----
    do_reset();
    chk("reset_state", state_o, 8'h01);
    chk("reset_valid", rnd_valid_o, 0);
    chk("reset_rnd", rnd_o, 0);
    chk("reset_fb", fallback_o, 0);

    // ---- table vectors ----
    for (int k = 0; k < NV; k++) begin
      if (tbl[k].rst) do_reset();
      en_i        = tbl[k].en;
      rnd_ready_i = tbl[k].rdy;
      limit_i     = tbl[k].lim;
      seed_we_i   = 1'b0;
      chk($sformatf("vec%0d_state", k), state_o, tbl[k].st);
      chk($sformatf("vec%0d_valid", k), rnd_valid_o, tbl[k].v);
      if (tbl[k].v) begin
        chk($sformatf("vec%0d_rnd", k), rnd_o, tbl[k].r);
        chk($sformatf("vec%0d_fb", k), fallback_o, tbl[k].f);
      end
      tick();
    end

    // ---- full period: 255 steps, never zero ----
    en_i = 1; rnd_ready_i = 1; limit_i = 0;
    do_reset();
    s = SEED; zero_seen = 0; first_ret = 0; mism = 0;
    for (int k = 1; k <= 255; k++) begin
      tick();
      s = model_step(s);
      if (state_o == 8'h00) zero_seen = 1;
      if (state_o !== s) mism++;
      if (state_o == SEED && first_ret == 0) first_ret = k;
    end
    chk("period_track", mism, 0);
    chk("period_nozero", zero_seen, 0);
    chk("period_len", first_ret, 255);

    // ---- backpressure ----
    en_i = 1; rnd_ready_i = 0; limit_i = 0;
    do_reset();
    tick();
    chk("bp_valid", rnd_valid_o, 1);
    chk("bp_rnd", rnd_o, 4'd1);
    s = 8'h02;
    for (int k = 0; k < 10; k++) begin
      tick();
      s = model_step(s);
      chk("bp_hold_valid", rnd_valid_o, 1);
      chk("bp_hold_rnd", rnd_o, 4'd1);
    end
    chk("bp_state_adv", state_o, s);
    rnd_ready_i = 1;
    tick();
    chk("bp_release", rnd_valid_o, 0);

    // ---- seed load ----
    en_i = 1; rnd_ready_i = 0; limit_i = 0;
    do_reset();
    tick();
    chk("seed_pre_valid", rnd_valid_o, 1);
    seed_we_i = 1; seed_i = 8'h5A;
    tick();
    seed_we_i = 0;
    chk("seed_state", state_o, 8'h5A);
    chk("seed_valid_drop", rnd_valid_o, 0);
    tick();
    chk("seed_restart_valid", rnd_valid_o, 1);
    chk("seed_restart_rnd", rnd_o, 4'hA);
    seed_we_i = 1; seed_i = 8'h00;
    tick();
    seed_we_i = 0;
    chk("seed_zero_state", state_o, SEED);
    chk("seed_zero_valid", rnd_valid_o, 0);

    // ---- async reset in VALID (holding a fallback sample) ----
    en_i = 1; rnd_ready_i = 0; limit_i = 4'd1;
    do_reset();
    for (int k = 0; k < 4; k++) tick();
    chk("ar_pre_fb", fallback_o, 1);
    chk("ar_pre_valid", rnd_valid_o, 1);
    #2 preset_n = 1'b0;
    #1;
    chk("ar_valid", rnd_valid_o, 0);
    chk("ar_rnd", rnd_o, 0);
    chk("ar_fb", fallback_o, 0);
    chk("ar_state", state_o, 8'h01);
    @(negedge clk);
    limit_i = 0;
    preset_n = 1'b1;
    tick();
    chk("ar_after_valid", rnd_valid_o, 1);
    chk("ar_after_rnd", rnd_o, 4'd1);
    chk("ar_after_state", state_o, 8'h02);

    // ---- randomized scoreboard run ----
    en_i = 0; rnd_ready_i = 0; limit_i = 0; seed_we_i = 0;
    do_reset();
    m_state = SEED; m_valid = 0; m_tries = 0;
    sb_q.delete();
    for (int c = 0; c < 600; c++) begin
      r_en   = ($urandom_range(0, 3) != 0);
      r_rdy  = $urandom_range(0, 1) == 1;
      r_lim  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      r_we   = ($urandom_range(0, 31) == 0);
      r_seed = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      en_i = r_en; rnd_ready_i = r_rdy; limit_i = r_lim;
      seed_we_i = r_we; seed_i = r_seed;

      chk("rnd_state", state_o, m_state);
      chk("rnd_valid", rnd_valid_o, m_valid);
      if (rnd_valid_o && r_rdy) begin
        got = {fallback_o, rnd_o};
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          exp_e = sb_q.pop_front();
          chk("sb_sample", got, exp_e);
        end
      end

      if (r_we) begin
        if (m_valid && !r_rdy) void'(sb_q.pop_back());
        m_state = (r_seed == 0) ? SEED : r_seed;
        m_valid = 0; m_tries = 0;
      end else begin
        if (m_valid) begin
          if (r_rdy) m_valid = 0;
        end else if (r_en) begin
          cand = m_state[3:0];
          if (r_lim == 0 || cand < r_lim) begin
            sb_q.push_back({1'b0, cand});
            m_valid = 1; m_tries = 0;
          end else if (m_tries == MT - 1) begin
            sb_q.push_back(5'b1_0000);
            m_valid = 1; m_tries = 0;
          end else begin
            m_tries++;
          end
        end
        if (r_en) m_state = model_step(m_state);
      end
      tick();
    end
    chk("sb_drain", sb_q.size(), m_valid ? 1 : 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/lfsr_random_gen.md
Name: lfsr_random_gen

Overview:
- Parametrised successor to the 4-bit random code generator.
- Contains a WIDTH-bit Fibonacci LFSR with a configurable tap mask, runtime seed load, enable and lock-up protection.
- Draws OUT_W-bit samples, optionally range-limited by rejection sampling, and delivers them over a valid/ready handshake.
- Feeds game/test logic that needs bounded pseudo-random codes, e.g. a symbol index below a runtime limit.

Parameters:
- WIDTH, 8: LFSR state width, 3..32.
- OUT_W, 4: sample width, 1..WIDTH; sample = state[OUT_W-1:0].
- TAPS, 8'hB8: feedback mask; bit i set means state[i] is XORed into the feedback bit. The default gives a maximal-length sequence, period 255.
- SEED, 8'h01: reset seed, also the substitute for any zero seed. Must be nonzero.
- MAX_TRIES, 4: consecutive rejections allowed before fallback, range 1..255.

Ports:
- clk, input, 1: rising-edge clock.
- preset_n, input, 1: asynchronous active-low reset.
- en_i, input, 1: advance LFSR and sampler this cycle.
- seed_we_i, input, 1: load seed this cycle.
- seed_i, input, WIDTH: seed value.
- limit_i, input, OUT_W: accept sample only if it is below limit_i. A value of 0 means no limit.
- rnd_valid_o, output, 1: sample available.
- rnd_ready_i, input, 1: consumer accepts sample.
- rnd_o, output, OUT_W: held sample.
- fallback_o, output, 1: current sample is a fallback 0 after MAX_TRIES rejections.
- state_o, output, WIDTH: raw LFSR state, for debug.

Behaviour:
- Reset (async, preset_n=0):
  - state=SEED, FSM=SEARCH, tries=0.
  - rnd_o=0, rnd_valid_o=0, fallback_o=0.
- LFSR step, when en_i=1 and seed_we_i=0:
  - next = {state[WIDTH-2:0], ^(state & TAPS)}.
  - If next==0 (defensive lock-up guard), load SEED instead.
  - en_i=0 freezes the LFSR and the FSM; the handshake still completes.
- Seed load (seed_we_i=1) has priority over stepping:
  - state <= (seed_i==0) ? SEED : seed_i.
  - FSM <= SEARCH, tries <= 0, rnd_valid_o <= 0, fallback_o <= 0.
  - If rnd_valid_o&rnd_ready_i in the same cycle, that transfer counts as completed.
- Candidate: cand = state[OUT_W-1:0] of the current cycle, before the step. It is accepted if limit_i==0 or cand < limit_i (unsigned).
- FSM SEARCH (rnd_valid_o=0), acts only when en_i=1:
  - Accept: rnd_o<=cand, fallback_o<=0, tries<=0, go to VALID.
  - Reject while tries<MAX_TRIES-1: tries<=tries+1.
  - Reject while tries==MAX_TRIES-1: rnd_o<=0, fallback_o<=1, tries<=0, go to VALID.
- FSM VALID (rnd_valid_o=1):
  - rnd_o and fallback_o are held stable until the transfer.
  - rnd_valid_o&rnd_ready_i: go to SEARCH. The next candidate is evaluated no earlier than the following cycle.
- Latency: with an accepting candidate, rnd_valid_o rises 1 cycle after the SEARCH cycle. Back-to-back transfers with ready held high complete every 2 cycles.
- limit_i is sampled each SEARCH cycle. A change during VALID has no effect on the held sample.
- The LFSR keeps stepping in VALID while en_i=1, so samples are decorrelated from stall time.
- rnd_ready_i is ignored while rnd_valid_o=0.

Decomposition:
- Package random_pkg:
  - FSM enum (SEARCH, VALID).
  - Default TAPS constants for widths 4, 8, 16 and 32 (4'h9, 8'hB8, 16'hB400, 32'h80200003).
  - Function lfsr_next(state, taps).
- Sub-module lfsr_core:
  - Owns state, seed load and the zero guard.
  - Ports: clk, preset_n, en, load, seed, state.
- Top: lfsr_random_gen holds the sampler FSM, try counter and output registers.

Test Plan:
- Free run: defaults, en_i=1, limit_i=0, no seed load.
  - state_o after reset: 01 → 02 → 04 → 08 → 11 → 23 → 47 → 8E.
  - 255 steps return to 01; no zero state ever appears.
- Rejection: limit_i=3, ready held 1, from reset.
  - Cycle0 accepts cand 1; cycle1 valid with rnd_o=1.
  - Candidates 4 and 8 are rejected.
  - Cycle4 accepts cand 1 (state 11); cycle5 valid with rnd_o=1 and fallback_o=0.
- Fallback: limit_i=1, MAX_TRIES=4, from reset.
  - Candidates 1, 2, 4, 8 are rejected.
  - Cycle4: rnd_valid_o=1, rnd_o=0, fallback_o=1.
- Backpressure: ready=0 for 10 cycles after valid.
  - rnd_o stays constant and valid stays high.
  - state_o advances 10 steps.
  - On ready=1 the transfer completes in 1 cycle.
- Seed load:
  - seed_i=8'h5A during VALID: state_o=5A next cycle, valid drops, sampling restarts.
  - seed_i=0: state_o=SEED=01.
  - seed_we_i with en_i=1 in the same cycle: the load wins and no step occurs.
- Async reset mid-operation: assert preset_n in VALID, between clock edges.
  - rnd_valid_o, rnd_o and fallback_o go to 0 immediately; state_o=01.
  - After release, the cycle-0 accept of the free-run sequence repeats.
